// File: rtl/vend_pkg.sv
// Shared coin codes, unit values, state encoding and coin valuation for the
// vending FSM family.
package vend_pkg;

  localparam logic [2:0] COIN_NONE    = 3'b000;
  localparam logic [2:0] COIN_NICKEL  = 3'b001;
  localparam logic [2:0] COIN_DIME    = 3'b010;
  localparam logic [2:0] COIN_QUARTER = 3'b101;

  localparam logic [2:0] NICKEL_VAL  = 3'd1;
  localparam logic [2:0] DIME_VAL    = 3'd2;
  localparam logic [2:0] QUARTER_VAL = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CREDIT = 2'b01,
    VEND   = 2'b10,
    CHANGE = 2'b11
  } vend_state_e;

  // Invalid codes are worth nothing, so callers treat a zero value as a reject.
  function automatic logic [2:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_NICKEL:  coin_value = NICKEL_VAL;
      COIN_DIME:    coin_value = DIME_VAL;
      COIN_QUARTER: coin_value = QUARTER_VAL;
      default:      coin_value = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_fsm_param_if.sv
// Coin-acceptor / dispenser / coin-return bundle seen by the vending FSM.
interface vend_fsm_param_if #(parameter int CREDIT_W = 6);

  logic                coin_valid;
  logic [2:0]          coin;
  logic                cancel;
  logic                coin_reject;
  logic                vend;
  logic                chg_valid;
  logic [2:0]          chg_coin;
  logic                chg_ready;
  logic [CREDIT_W-1:0] credit;
  logic [1:0]          state;
  logic                busy;

  modport master (
    output coin_valid, coin, cancel, chg_ready,
    input  coin_reject, vend, chg_valid, chg_coin, credit, state, busy
  );

  modport slave (
    input  coin_valid, coin, cancel, chg_ready,
    output coin_reject, vend, chg_valid, chg_coin, credit, state, busy
  );

endinterface

// File: rtl/vend_change_sel.sv
// Greedy change picker: largest coin whose value fits in the remaining credit.
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] credit_i,
  output logic [2:0]          coin_o,
  output logic [CREDIT_W-1:0] value_o
);

  always_comb begin
    coin_o  = COIN_NONE;
    value_o = '0;
    if (credit_i >= CREDIT_W'(QUARTER_VAL)) begin
      coin_o  = COIN_QUARTER;
      value_o = CREDIT_W'(QUARTER_VAL);
    end else if (credit_i >= CREDIT_W'(DIME_VAL)) begin
      coin_o  = COIN_DIME;
      value_o = CREDIT_W'(DIME_VAL);
    end else if (credit_i >= CREDIT_W'(NICKEL_VAL)) begin
      coin_o  = COIN_NICKEL;
      value_o = CREDIT_W'(NICKEL_VAL);
    end
  end

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised coin FSM: accumulates credit up to a cap, vends at PRICE and
// pays back change or cancelled credit one coin at a time over valid/ready.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 6,
  parameter int PRICE      = 5,
  parameter int MAX_CREDIT = 9
) (
  input logic         clock,
  input logic         reset,
  vend_fsm_param_if.slave bus
);

  localparam logic [CREDIT_W-1:0] PriceC = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MaxC   = (CREDIT_W + 1)'(MAX_CREDIT);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;

  logic [2:0]          coinVal;
  logic [CREDIT_W:0]   creditSum;
  logic                coinOk;
  logic [2:0]          selCode;
  logic [CREDIT_W-1:0] selValue;
  logic [CREDIT_W-1:0] afterVend;
  logic [CREDIT_W-1:0] afterChange;

  vend_change_sel #(.CREDIT_W(CREDIT_W)) uChangeSel (
    .credit_i (credit_q),
    .coin_o   (selCode),
    .value_o  (selValue)
  );

  // One extra bit on the sum so the cap comparison cannot wrap.
  assign coinVal     = coin_value(bus.coin);
  assign creditSum   = {1'b0, credit_q} + (CREDIT_W + 1)'(coinVal);
  assign coinOk      = (coinVal != 3'd0) && (creditSum <= MaxC);
  assign afterVend   = credit_q - PriceC;
  assign afterChange = credit_q - selValue;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE, CREDIT: begin
        if ((state_q == CREDIT) && bus.cancel) begin
          state_d  = CHANGE;
          reject_d = bus.coin_valid;
        end else if (bus.coin_valid) begin
          if (coinOk) begin
            credit_d = creditSum[CREDIT_W-1:0];
            state_d  = (creditSum >= {1'b0, PriceC}) ? VEND : CREDIT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      VEND: begin
        reject_d = bus.coin_valid;
        credit_d = afterVend;
        state_d  = (afterVend != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_d = bus.coin_valid;
        if (bus.chg_ready) begin
          credit_d = afterChange;
          if (afterChange == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  assign bus.coin_reject = reject_q;
  assign bus.vend        = (state_q == VEND);
  assign bus.chg_valid   = (state_q == CHANGE);
  assign bus.chg_coin    = (state_q == CHANGE) ? selCode : COIN_NONE;
  assign bus.credit      = credit_q;
  assign bus.state       = state_q;
  assign bus.busy        = (state_q == VEND) || (state_q == CHANGE);

  creditCapA: assert property (@(posedge clock) disable iff (!reset)
    {1'b0, credit_q} <= MaxC);

endmodule

// File: tb/tb_vend_fsm_param.sv
// Bench for vend_fsm_param: directed scenarios plus a randomized run checked
// against a transaction-level coin model, on a default and a low-cap instance.
module tb_vend_fsm_param;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic coinValid = 1'b0;
  logic [2:0] coinCode = 3'b000;
  logic cancelIn = 1'b0;
  logic chgReady = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [14:0] obsA, obsB, expV;

  always #5 clock = ~clock;

  vend_fsm_param_if #(.CREDIT_W(6)) ifA ();
  vend_fsm_param_if #(.CREDIT_W(6)) ifB ();

  assign ifA.coin_valid = coinValid;
  assign ifA.coin       = coinCode;
  assign ifA.cancel     = cancelIn;
  assign ifA.chg_ready  = chgReady;
  assign ifB.coin_valid = coinValid;
  assign ifB.coin       = coinCode;
  assign ifB.cancel     = cancelIn;
  assign ifB.chg_ready  = chgReady;

  vend_fsm_param #(.CREDIT_W(6), .PRICE(5), .MAX_CREDIT(9)) dutA (
    .clock (clock),
    .reset (reset),
    .bus   (ifA)
  );

  vend_fsm_param #(.CREDIT_W(6), .PRICE(5), .MAX_CREDIT(6)) dutB (
    .clock (clock),
    .reset (reset),
    .bus   (ifB)
  );

  assign obsA = {ifA.state, ifA.credit, ifA.vend, ifA.chg_valid, ifA.chg_coin, ifA.busy, ifA.coin_reject};
  assign obsB = {ifB.state, ifB.credit, ifB.vend, ifB.chg_valid, ifB.chg_coin, ifB.busy, ifB.coin_reject};

  // Expected output bundle: vend, chg_valid and busy follow directly from state.
  function automatic logic [14:0] snap(input logic [1:0] st, input logic [5:0] cr,
                                       input logic [2:0] chg, input logic rej);
    snap = {st, cr, st == S_VEND, st == S_CHANGE, chg, (st == S_VEND) || (st == S_CHANGE), rej};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic resetBoth();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic applyStimulus(input logic cv, input logic [2:0] code, input logic cn, input logic rdy);
    coinValid = cv;
    coinCode  = code;
    cancelIn  = cn;
    chgReady  = rdy;
  endtask

  task automatic test_reset();
    applyStimulus(0, 3'b000, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    expV = snap(S_IDLE, 6'd0, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL reset_A got %b want %b", obsA, expV); end
    vectors++; if (obsB !== expV) begin miscompares++; $display("[TB] FAIL reset_B got %b want %b", obsB, expV); end
    @(negedge clock);
    reset = 1'b1;
    tick();
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL release_A got %b want %b", obsA, expV); end
  endtask

  task automatic test_nickels();
    applyStimulus(1, 3'b001, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(); expV = snap(S_CREDIT, 6'(i), 3'b000, 1'b0);
      vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL nickel%0d got %b want %b", i, obsA, expV); end
    end
    tick(); expV = snap(S_VEND, 6'd5, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL nickel_vend got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 0, 0);
    tick(); expV = snap(S_IDLE, 6'd0, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL nickel_done got %b want %b", obsA, expV); end
  endtask

  task automatic test_dime_quarter();
    applyStimulus(1, 3'b010, 0, 0);
    tick(); expV = snap(S_CREDIT, 6'd2, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL dq_dime got %b want %b", obsA, expV); end
    applyStimulus(1, 3'b101, 0, 0);
    tick(); expV = snap(S_VEND, 6'd7, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL dq_vend got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 0, 1);
    tick(); expV = snap(S_CHANGE, 6'd2, 3'b010, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL dq_change got %b want %b", obsA, expV); end
    tick(); expV = snap(S_IDLE, 6'd0, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL dq_idle got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 0, 0);
  endtask

  task automatic test_cancel();
    applyStimulus(1, 3'b001, 0, 0);
    tick();
    applyStimulus(1, 3'b010, 0, 0);
    tick(); expV = snap(S_CREDIT, 6'd3, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL cancel_credit got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 1, 0);
    tick(); expV = snap(S_CHANGE, 6'd3, 3'b010, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL cancel_dime got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 0, 1);
    tick(); expV = snap(S_CHANGE, 6'd1, 3'b001, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL cancel_nickel got %b want %b", obsA, expV); end
    tick(); expV = snap(S_IDLE, 6'd0, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL cancel_idle got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 0, 0);
  endtask

  task automatic test_ready_stall();
    applyStimulus(1, 3'b010, 0, 0);
    tick(); tick(); expV = snap(S_CREDIT, 6'd4, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL stall_credit got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 1, 0);
    tick();
    applyStimulus(0, 3'b000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      expV = snap(S_CHANGE, 6'd4, 3'b010, 1'b0);
      vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL stall_hold%0d got %b want %b", i, obsA, expV); end
      tick();
    end
    chgReady = 1'b1;
    tick(); expV = snap(S_CHANGE, 6'd2, 3'b010, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL stall_xfer got %b want %b", obsA, expV); end
    tick(); expV = snap(S_IDLE, 6'd0, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL stall_idle got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 0, 0);
  endtask

  task automatic test_reject();
    logic [2:0] badCodes [5] = '{3'b011, 3'b000, 3'b100, 3'b110, 3'b111};
    foreach (badCodes[i]) begin
      applyStimulus(1, badCodes[i], 0, 0);
      tick(); expV = snap(S_IDLE, 6'd0, 3'b000, 1'b1);
      vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL bad_code_%b got %b want %b", badCodes[i], obsA, expV); end
    end
    applyStimulus(0, 3'b000, 0, 0);
    tick(); expV = snap(S_IDLE, 6'd0, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL bad_code_clear got %b want %b", obsA, expV); end
    applyStimulus(1, 3'b001, 0, 0);
    tick();
    applyStimulus(1, 3'b010, 1, 0);
    tick(); expV = snap(S_CHANGE, 6'd1, 3'b001, 1'b1);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL cancel_wins got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 0, 0);
    tick(); expV = snap(S_CHANGE, 6'd1, 3'b001, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL cancel_wins_clear got %b want %b", obsA, expV); end
    applyStimulus(1, 3'b101, 0, 0);
    tick(); expV = snap(S_CHANGE, 6'd1, 3'b001, 1'b1);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL coin_in_change got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 0, 0);
    tick(); expV = snap(S_CHANGE, 6'd1, 3'b001, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL coin_in_change_clear got %b want %b", obsA, expV); end
    chgReady = 1'b1;
    tick(); expV = snap(S_IDLE, 6'd0, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL reject_idle got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 0, 0);
  endtask

  task automatic test_cap();
    resetBoth();
    applyStimulus(1, 3'b010, 0, 0);
    tick(); expV = snap(S_CREDIT, 6'd2, 3'b000, 1'b0);
    vectors++; if (obsB !== expV) begin miscompares++; $display("[TB] FAIL cap_dime got %b want %b", obsB, expV); end
    applyStimulus(1, 3'b101, 0, 0);
    tick(); expV = snap(S_CREDIT, 6'd2, 3'b000, 1'b1);
    vectors++; if (obsB !== expV) begin miscompares++; $display("[TB] FAIL cap_quarter_rej got %b want %b", obsB, expV); end
    applyStimulus(1, 3'b010, 0, 0);
    tick(); expV = snap(S_CREDIT, 6'd4, 3'b000, 1'b0);
    vectors++; if (obsB !== expV) begin miscompares++; $display("[TB] FAIL cap_dime2 got %b want %b", obsB, expV); end
    tick(); expV = snap(S_VEND, 6'd6, 3'b000, 1'b0);
    vectors++; if (obsB !== expV) begin miscompares++; $display("[TB] FAIL cap_exact got %b want %b", obsB, expV); end
    applyStimulus(0, 3'b000, 0, 0);
    tick(); expV = snap(S_CHANGE, 6'd1, 3'b001, 1'b0);
    vectors++; if (obsB !== expV) begin miscompares++; $display("[TB] FAIL cap_change got %b want %b", obsB, expV); end
    chgReady = 1'b1;
    tick(); expV = snap(S_IDLE, 6'd0, 3'b000, 1'b0);
    vectors++; if (obsB !== expV) begin miscompares++; $display("[TB] FAIL cap_idle got %b want %b", obsB, expV); end
    applyStimulus(0, 3'b000, 0, 0);
  endtask

  task automatic test_reset_mid();
    resetBoth();
    applyStimulus(1, 3'b001, 0, 0);
    tick();
    applyStimulus(1, 3'b010, 0, 0);
    tick();
    applyStimulus(0, 3'b000, 1, 0);
    tick(); expV = snap(S_CHANGE, 6'd3, 3'b010, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL mid_setup got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 0, 0);
    #2 reset = 1'b0;
    #1 expV = snap(S_IDLE, 6'd0, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL mid_async got %b want %b", obsA, expV); end
    @(negedge clock);
    reset = 1'b1;
    tick();
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL mid_release got %b want %b", obsA, expV); end
    applyStimulus(1, 3'b001, 0, 0);
    tick(); expV = snap(S_CREDIT, 6'd1, 3'b000, 1'b0);
    vectors++; if (obsA !== expV) begin miscompares++; $display("[TB] FAIL mid_resume got %b want %b", obsA, expV); end
    applyStimulus(0, 3'b000, 0, 0);
  endtask

  // Transaction-level coin model: 0 idle, 1 holding credit, 2 vending, 3 paying back.
  int mCredit [2];
  int mPhase  [2];
  logic mRej  [2];
  int maxCredit [2] = '{9, 6};

  function automatic int unitsOf(input logic [2:0] code);
    if (code == 3'b001) return 1;
    if (code == 3'b010) return 2;
    if (code == 3'b101) return 5;
    return 0;
  endfunction

  function automatic int changeUnits(input int c);
    if (c >= 5) return 5;
    if (c >= 2) return 2;
    if (c >= 1) return 1;
    return 0;
  endfunction

  function automatic logic [2:0] codeOf(input int u);
    if (u == 5) return 3'b101;
    if (u == 2) return 3'b010;
    if (u == 1) return 3'b001;
    return 3'b000;
  endfunction

  task automatic modelStep(input int k);
    int v;
    mRej[k] = 1'b0;
    if (mPhase[k] <= 1) begin
      if (mPhase[k] == 1 && cancelIn) begin
        mPhase[k] = 3;
        mRej[k] = coinValid;
      end else if (coinValid) begin
        v = unitsOf(coinCode);
        if (v != 0 && mCredit[k] + v <= maxCredit[k]) begin
          mCredit[k] += v;
          mPhase[k] = (mCredit[k] >= 5) ? 2 : 1;
        end else begin
          mRej[k] = 1'b1;
        end
      end
    end else if (mPhase[k] == 2) begin
      mRej[k] = coinValid;
      mCredit[k] -= 5;
      mPhase[k] = (mCredit[k] > 0) ? 3 : 0;
    end else begin
      mRej[k] = coinValid;
      if (chgReady) begin
        mCredit[k] -= changeUnits(mCredit[k]);
        if (mCredit[k] == 0) mPhase[k] = 0;
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [14:0] obs;
    resetBoth();
    for (int k = 0; k < 2; k++) begin mCredit[k] = 0; mPhase[k] = 0; mRej[k] = 1'b0; end
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
          mCredit[k] = 0; mPhase[k] = 0; mRej[k] = 1'b0;
          obs = (k == 0) ? obsA : obsB;
          expV = snap(S_IDLE, 6'd0, 3'b000, 1'b0);
          vectors++; if (obs !== expV) begin miscompares++; $display("[TB] FAIL rand_reset dut%0d n=%0d got %b want %b", k, n, obs, expV); end
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
      end else begin
        r = int'($urandom_range(0, 9));
        coinValid = ($urandom_range(0, 9) < 4);
        coinCode  = (r < 3) ? 3'b001 : (r < 5) ? 3'b010 : (r < 7) ? 3'b101 : 3'($urandom_range(0, 7));
        cancelIn  = ($urandom_range(0, 11) == 0);
        chgReady  = 1'($urandom_range(0, 1));
        @(posedge clock);
        modelStep(0);
        modelStep(1);
        #1;
        for (int k = 0; k < 2; k++) begin
          obs = (k == 0) ? obsA : obsB;
          expV = snap(2'(mPhase[k]), 6'(mCredit[k]),
                      (mPhase[k] == 3) ? codeOf(changeUnits(mCredit[k])) : 3'b000, mRej[k]);
          vectors++; if (obs !== expV) begin miscompares++; $display("[TB] FAIL rand dut%0d n=%0d got %b want %b", k, n, obs, expV); end
        end
      end
    end
    applyStimulus(0, 3'b000, 0, 0);
  endtask

  initial begin
    test_reset();
    test_nickels();
    test_dime_quarter();
    test_cancel();
    test_ready_stall();
    test_reject();
    test_cap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vend_fsm_param.md
Name: vend_fsm_param

Overview:
Parametrised successor to the single-price coin FSM. Accumulates nickel/dime/quarter credit up to a programmable cap and vends once credit reaches a programmable price. It returns change, or the full credit on cancel, one coin at a time over a valid/ready handshake to the coin-return mechanism. It sits between the coin acceptor front-end and the dispenser/coin-return actuators.

Parameters:
CREDIT_W, 6, width of the credit register in 5c units; requires MAX_CREDIT < 2**CREDIT_W.
PRICE, 5, item price in 5c units (default 25c); requires 1 <= PRICE <= MAX_CREDIT.
MAX_CREDIT, 9, maximum credit held in 5c units; a coin that would exceed it is rejected.

Ports:
clock  in  1  system clock; all state changes on rising edge.
reset  in  1  asynchronous, active-low reset.
coin_valid  in  1  one-cycle strobe; coin code on coin is meaningful.
coin  in  3  coin code: 001 nickel (1 unit), 010 dime (2), 101 quarter (5); all other codes invalid.
cancel  in  1  level/strobe; return all credit without vending.
coin_reject  out  1  one-cycle pulse; presented coin not credited (physically returned).
vend  out  1  one-cycle pulse; dispense one item.
chg_valid  out  1  a change coin is offered on chg_coin.
chg_coin  out  3  change coin code (001/010/101); 000 when chg_valid=0.
chg_ready  in  1  coin-return mechanism accepts the offered coin.
credit  out  CREDIT_W  current credit in 5c units.
state  out  2  current FSM state: 00 IDLE, 01 CREDIT, 10 VEND, 11 CHANGE.
busy  out  1  high in VEND or CHANGE.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low.
- Reset (reset=0): immediately state=IDLE, credit=0, coin_reject=0, vend=0, chg_valid=0, chg_coin=000, busy=0. Applies mid-operation. Any pending change is forfeited. No output glitches to 1 on release.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- IDLE/CREDIT, coin_valid=1:
  - Valid code and credit+value <= MAX_CREDIT: credit += value at that edge; state -> CREDIT.
  - Otherwise coin_reject=1 for the next cycle; credit and state unchanged.
- After the accepting edge, if updated credit >= PRICE, state goes to VEND at the same edge, i.e. vend is high in the cycle after the coin strobe.
- VEND: vend=1 for exactly one cycle; credit shows the pre-purchase value. At the exit edge credit -= PRICE. If the result is >0, go to CHANGE; otherwise go to IDLE.
- cancel=1 in CREDIT (no coin accepted that cycle; cancel wins over a simultaneous coin_valid, and that coin gets coin_reject) -> CHANGE, credit unchanged, no vend. Cancel is ignored in IDLE, VEND and CHANGE.
- CHANGE:
  - chg_valid=1. chg_coin = largest coin with value <= credit (quarter, then dime, then nickel).
  - Transfer happens on an edge with chg_valid & chg_ready: credit -= coin value. If the result is 0, go to IDLE (chg_valid low next cycle); otherwise stay and offer the next coin.
  - chg_coin is stable while chg_valid=1 and chg_ready=0. No timeout.
- coin_valid in VEND or CHANGE: coin_reject pulse; credit untouched.
- Credit arithmetic is unsigned CREDIT_W wide. Given the cap check, it can never overflow or underflow. An assertion flags credit > MAX_CREDIT.
- Invalid coin codes (000, 011, 100, 110, 111) are always rejected, never credited.
- Unreachable state encodings recover to IDLE with credit cleared.

Decomposition:
- Package vend_pkg holds:
  - coin code constants (COIN_NICKEL=001, COIN_DIME=010, COIN_QUARTER=101);
  - unit values (1, 2, 5);
  - state encodings (IDLE, CREDIT, VEND, CHANGE);
  - a function mapping coin code to value (0 for invalid).
- One sub-module: vend_change_sel, a combinational greedy picker. Input credit; outputs chg_coin code and its value. It is reused by the multi-price variant.

Test Plan:
- Reset, then five nickels (PRICE=5) -> credit 1..5; vend=1 one cycle after 5th strobe; no chg_valid; credit 0; state IDLE.
- Dime then quarter -> credit 2 then 7; vend pulse; CHANGE offers chg_coin=010; with chg_ready=1 one transfer, then credit 0, IDLE.
- Nickel, dime, then cancel -> no vend; chg_coin 010 accepted then 001 accepted; credit 3->1->0; IDLE.
- Cancel with credit 4 and chg_ready held low 4 cycles -> chg_valid=1 and chg_coin=010 stable throughout; transfer on first ready cycle.
- Invalid code 011, and (MAX_CREDIT=6) quarter at credit 2, and coin during CHANGE -> each yields one-cycle coin_reject; credit unchanged.
- reset driven low mid-CHANGE (credit 3) -> chg_valid, vend, credit, state all 0 immediately, before next edge; normal operation after release.
